// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 1280x800@60 display path.
// Two wrap counters (x per pixel, y per line) with all outputs registered and
// decoded from the next-state counter values, so sync/visible/pulses always
// describe the same pixel as display_pos_x/y.
// Counter origin is the start of sync: sync, back porch, active, front porch.
// Legal parameter range: H_TOTAL <= 2048, V_TOTAL <= 1024.

module vga_timing_gen #(
    parameter int   H_SYNC    = 136,
    parameter int   H_BP      = 200,
    parameter int   H_ACTIVE  = 1280,
    parameter int   H_FP      = 64,
    parameter int   V_SYNC    = 3,
    parameter int   V_BP      = 24,
    parameter int   V_ACTIVE  = 800,
    parameter int   V_FP      = 1,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    output logic [10:0] display_pos_x,
    output logic [9:0]  display_pos_y,
    output logic        hsync,
    output logic        vsync,
    output logic        visible,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_count
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    // Terminal counts and window bounds at full port width.
    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [9:0]  V_SYNC_END  = 10'(V_SYNC);
    localparam logic [10:0] H_VIS_FIRST = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_VIS_LAST  = 11'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [9:0]  V_VIS_FIRST = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_VIS_LAST  = 10'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic        x_wrap;
    logic        y_wrap;
    logic [10:0] x_nxt;
    logic [9:0]  y_nxt;
    logic        hsync_nxt;
    logic        vsync_nxt;
    logic        visible_nxt;

    // Next position and its decode, used whenever pix_en advances the raster.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        x_wrap      = 1'b0;
        y_wrap      = 1'b0;
        x_nxt       = display_pos_x;
        y_nxt       = display_pos_y;
        hsync_nxt   = ~HSYNC_POL;
        vsync_nxt   = ~VSYNC_POL;
        visible_nxt = 1'b0;

        x_wrap = (display_pos_x == H_LAST);
        y_wrap = (display_pos_y == V_LAST);

        if (x_wrap) begin
            x_nxt = 11'd0;
            y_nxt = y_wrap ? 10'd0 : display_pos_y + 10'd1;
        end else begin
            x_nxt = display_pos_x + 11'd1;
        end

        if (x_nxt < H_SYNC_END) hsync_nxt = HSYNC_POL;
        if (y_nxt < V_SYNC_END) vsync_nxt = VSYNC_POL;

        visible_nxt = (x_nxt >= H_VIS_FIRST) && (x_nxt <= H_VIS_LAST) &&
                      (y_nxt >= V_VIS_FIRST) && (y_nxt <= V_VIS_LAST);
    end

    // Registered raster state: reset to (0,0) in sync, advance on pix_en, else hold.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            display_pos_x <= 11'd0;
            display_pos_y <= 10'd0;
            hsync         <= HSYNC_POL;
            vsync         <= VSYNC_POL;
            visible       <= 1'b0;
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
            frame_count   <= 8'd0;
        end else if (pix_en) begin
            display_pos_x <= x_nxt;
            display_pos_y <= y_nxt;
            hsync         <= hsync_nxt;
            vsync         <= vsync_nxt;
            visible       <= visible_nxt;
            line_start    <= x_wrap;
            frame_start   <= x_wrap && y_wrap;
            if (x_wrap && y_wrap) frame_count <= frame_count + 8'd1;
        end else begin
            line_start    <= 1'b0;
            frame_start   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen.
// Two instances share clk/rst/pix_en: one with the default 1680x828 raster and
// one with a tiny raster so that whole frames fit in a short run. Each is
// compared every cycle against a model that tracks a linear pixel index.

module tb_vga_timing_gen;

    typedef struct {
        int ht;   // total pixels per line
        int hs;   // hsync width
        int hvf;  // first visible x
        int hvl;  // last visible x
        int vt;   // total lines
        int vs;   // vsync width
        int vvf;  // first visible y
        int vvl;  // last visible y
    } cfg_t;

    typedef struct {
        int p;    // linear pixel index y*ht + x
        int fc;
        int ls;
        int fs;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_en = 1'b0;

    logic [10:0] d_x;  logic [9:0] d_y;
    logic        d_hs, d_vs, d_vis, d_ls, d_fs;
    logic [7:0]  d_fc;

    logic [10:0] s_x;  logic [9:0] s_y;
    logic        s_hs, s_vs, s_vis, s_ls, s_fs;
    logic [7:0]  s_fc;

    int checks = 0;
    int errors = 0;

    // Default raster: 136/200/1280/64 x 3/24/800/1
    cfg_t cd = '{ht: 1680, hs: 136, hvf: 336, hvl: 1615,
                 vt: 828,  vs: 3,   vvf: 27,  vvl: 826};
    // Small raster: 4/5/16/3 x 2/3/6/2
    cfg_t cs = '{ht: 28, hs: 4, hvf: 9, hvl: 24,
                 vt: 13, vs: 2, vvf: 5, vvl: 10};

    mdl_t md = '{p: 0, fc: 0, ls: 0, fs: 0};
    mdl_t ms = '{p: 0, fc: 0, ls: 0, fs: 0};

    always #5 clk = ~clk;

    vga_timing_gen u_dut_def (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .display_pos_x(d_x), .display_pos_y(d_y),
        .hsync(d_hs), .vsync(d_vs), .visible(d_vis),
        .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
    );

    vga_timing_gen #(
        .H_SYNC(4), .H_BP(5), .H_ACTIVE(16), .H_FP(3),
        .V_SYNC(2), .V_BP(3), .V_ACTIVE(6),  .V_FP(2)
    ) u_dut_small (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .display_pos_x(s_x), .display_pos_y(s_y),
        .hsync(s_hs), .vsync(s_vs), .visible(s_vis),
        .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Model advances a linear pixel index through the frame.
    function automatic mdl_t mdl_step(input cfg_t c, input mdl_t m, input bit r, input bit e);
        mdl_t n = m;
        if (r) begin
            n = '{p: 0, fc: 0, ls: 0, fs: 0};
        end else if (e) begin
            n.p  = (m.p + 1) % (c.ht * c.vt);
            n.ls = (n.p % c.ht == 0) ? 1 : 0;
            n.fs = (n.p == 0) ? 1 : 0;
            if (n.fs == 1) n.fc = (m.fc + 1) % 256;
        end else begin
            n.ls = 0;
            n.fs = 0;
        end
        return n;
    endfunction

    task automatic check_dut(input string n, input cfg_t c, input mdl_t m,
                             input int x, input int y, input int hs, input int vs,
                             input int vis, input int ls, input int fs, input int fc);
        int ex, ey, evis;
        ex   = m.p % c.ht;
        ey   = m.p / c.ht;
        evis = (ex >= c.hvf && ex <= c.hvl && ey >= c.vvf && ey <= c.vvl) ? 1 : 0;
        check({n, "_x"},  x, ex);
        check({n, "_y"},  y, ey);
        check({n, "_hsync"}, hs, (ex < c.hs) ? 0 : 1);   // active low
        check({n, "_vsync"}, vs, (ey < c.vs) ? 1 : 0);   // active high
        check({n, "_visible"}, vis, evis);
        check({n, "_line_start"}, ls, m.ls);
        check({n, "_frame_start"}, fs, m.fs);
        check({n, "_frame_count"}, fc, m.fc);
    endtask

    // One clock: apply inputs, step models at the edge, compare 1 ns later.
    task automatic cycle(input bit r, input bit e);
        rst    = r;
        pix_en = e;
        @(posedge clk);
        md = mdl_step(cd, md, r, e);
        ms = mdl_step(cs, ms, r, e);
        #1;
        check_dut("def", cd, md, int'(d_x), int'(d_y), int'(d_hs), int'(d_vs),
                  int'(d_vis), int'(d_ls), int'(d_fs), int'(d_fc));
        check_dut("sml", cs, ms, int'(s_x), int'(s_y), int'(s_hs), int'(s_vs),
                  int'(s_vis), int'(s_ls), int'(s_fs), int'(s_fc));
    endtask

    initial begin
        int n, vis_cnt, vs_cnt, fs_cnt, ls_cnt;

        // Reset state, held across pix_en values.
        cycle(1, 0);
        cycle(1, 1);
        check("rst_hsync", int'(d_hs), 0);
        check("rst_vsync", int'(d_vs), 1);
        check("rst_line_start", int'(d_ls), 0);

        // First enabled step after reset.
        cycle(0, 1);
        check("first_x", int'(d_x), 1);
        check("first_y", int'(d_y), 0);
        check("first_visible", int'(d_vis), 0);

        // Full small frame from reset: visible/vsync/frame_start accounting.
        cycle(1, 0);
        vis_cnt = 0; vs_cnt = 0; fs_cnt = 0;
        for (int i = 0; i < 28 * 13; i++) begin
            cycle(0, 1);
            vis_cnt += int'(s_vis);
            vs_cnt  += int'(s_vs);
            fs_cnt  += int'(s_fs);
        end
        check("frame_visible_count", vis_cnt, 16 * 6);
        check("frame_vsync_count", vs_cnt, 2 * 28);
        check("frame_start_count", fs_cnt, 1);
        check("frame_count_one", int'(s_fc), 1);
        check("frame_end_x", int'(s_x), 0);
        check("frame_end_y", int'(s_y), 0);

        // Visible edges on the first visible line of the small raster.
        n = 0;
        while (!(s_x == 11'(cs.hvf - 1) && s_y == 10'(cs.vvf)) && n < 1000) begin
            cycle(0, 1); n++;
        end
        check("reach_vis_start", (n < 1000) ? 1 : 0, 1);
        check("vis_before_start", int'(s_vis), 0);
        cycle(0, 1);
        check("vis_at_start", int'(s_vis), 1);
        n = 0;
        while (s_x != 11'(cs.hvl) && n < 100) begin
            cycle(0, 1); n++;
        end
        check("vis_at_last", int'(s_vis), 1);
        cycle(0, 1);
        check("vis_after_last", int'(s_vis), 0);

        // pix_en 1,0,0,1 around the line wrap.
        n = 0;
        while (s_x != 11'(cs.ht - 2) && n < 100) begin
            cycle(0, 1); n++;
        end
        ls_cnt = 0;
        cycle(0, 1); ls_cnt += int'(s_ls);
        cycle(0, 0); ls_cnt += int'(s_ls);
        check("freeze_x", int'(s_x), cs.ht - 1);
        cycle(0, 0); ls_cnt += int'(s_ls);
        cycle(0, 1); ls_cnt += int'(s_ls);
        check("wrap_line_start", int'(s_ls), 1);
        check("wrap_x", int'(s_x), 0);
        cycle(0, 0); ls_cnt += int'(s_ls);
        check("line_start_width", ls_cnt, 1);

        // Reset while inside the visible window.
        n = 0;
        while (s_vis != 1'b1 && n < 1000) begin
            cycle(0, 1); n++;
        end
        check("reach_visible", int'(s_vis), 1);
        cycle(1, 1);
        check("midrst_x", int'(s_x), 0);
        check("midrst_y", int'(s_y), 0);
        check("midrst_visible", int'(s_vis), 0);
        check("midrst_frame_count", int'(s_fc), 0);
        check("midrst_hsync", int'(s_hs), 0);
        check("midrst_vsync", int'(s_vs), 1);

        // Default raster: run through the first line wrap (hsync edge at 136).
        cycle(1, 0);
        for (int i = 0; i < 1679; i++) cycle(0, 1);
        check("def_x_last", int'(d_x), 1679);
        check("def_hsync_idle", int'(d_hs), 1);
        cycle(0, 1);
        check("def_wrap_x", int'(d_x), 0);
        check("def_wrap_y", int'(d_y), 1);
        check("def_wrap_ls", int'(d_ls), 1);
        check("def_wrap_fs", int'(d_fs), 0);
        check("def_wrap_hsync", int'(d_hs), 0);

        // Randomized enable pattern with occasional resets.
        for (int i = 0; i < 12000; i++) begin
            cycle(($urandom_range(0, 1499) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
